// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, state/fault enums and access-size helper for the LSU
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_ILLEGAL  = 2'b10,
      FAULT_TIMEOUT  = 2'b11
   } lsu_fault_t;

   // Access size in bytes; the low two funct3 bits encode log2(size).
   function automatic logic [3:0] size_of(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   size_of = 4'd1;
         2'b01:   size_of = 4'd2;
         2'b10:   size_of = 4'd4;
         default: size_of = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication / byte enables and load shift / extension
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]                   funct3,
   input  logic [$clog2(XLEN/8)-1:0]    lane,
   input  logic [XLEN-1:0]              store_data,
   input  logic [XLEN-1:0]              load_raw,
   output logic [XLEN-1:0]              store_lanes,
   output logic [XLEN/8-1:0]            byte_en,
   output logic [XLEN-1:0]              load_result
);

   localparam int NB = XLEN / 8;

   logic [NB-1:0]   size_mask;
   logic [XLEN-1:0] shifted;

   // Replicate the store operand so every lane carries it; byte_en picks the live lanes.
   always_comb begin
      store_lanes = store_data;
      size_mask   = '1;
      case (funct3[1:0])
         2'b00: begin
            store_lanes = {NB{store_data[7:0]}};
            size_mask   = NB'(4'h1);
         end
         2'b01: begin
            store_lanes = {(NB/2){store_data[15:0]}};
            size_mask   = NB'(4'h3);
         end
         2'b10: begin
            store_lanes = {(NB/4){store_data[31:0]}};
            size_mask   = NB'(4'hF);
         end
         default: begin
            store_lanes = store_data;
            size_mask   = '1;
         end
      endcase
      byte_en = size_mask << lane;
   end

   assign shifted = load_raw >> {lane, 3'b000};

   // Bring the addressed lane down to bit 0 and extend it to full width.
   always_comb begin
      load_result = shifted;
      case (funct3)
         F3_B:    load_result = XLEN'(signed'(shifted[7:0]));
         F3_H:    load_result = XLEN'(signed'(shifted[15:0]));
         F3_W:    load_result = XLEN'(signed'(shifted[31:0]));
         F3_BU:   load_result = XLEN'(shifted[7:0]);
         F3_HU:   load_result = XLEN'(shifted[15:0]);
         F3_WU:   load_result = XLEN'(shifted[31:0]);
         default: load_result = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_handshake.sv
// rtl/lsu_handshake.sv - variable-latency load/store unit with request/ready memory handshake
module lsu_handshake
   import lsu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ex_valid,
   input  logic                ex_load,
   input  logic                ex_store,
   input  logic [2:0]          ex_funct3,
   input  logic [XLEN-1:0]     ex_addr,
   input  logic [XLEN-1:0]     ex_store_data,
   input  logic [4:0]          ex_rd,
   output logic                lsu_stall,
   output logic                wb_valid,
   output logic [4:0]          wb_rd,
   output logic [XLEN-1:0]     wb_data,
   output logic                fault,
   output logic [1:0]          fault_cause,
   output logic [XLEN-1:0]     mem_address,
   output logic [XLEN-1:0]     mem_input,
   output logic [XLEN/8-1:0]   mem_byte_en,
   output logic                mem_enable,
   output logic                mem_r_w,
   input  logic                mem_ready,
   input  logic [XLEN-1:0]     mem_output
);

   localparam int NB = XLEN / 8;
   localparam int LW = $clog2(NB);
   localparam int CW = $clog2(MAX_WAIT + 1);

   lsu_state_t      state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [XLEN-1:0] op_addr, op_data;
   logic [2:0]      op_funct3;
   logic [4:0]      op_rd;
   logic            op_store;
   logic            fault_r, fault_n;
   lsu_fault_t      cause_r, cause_n;
   logic [4:0]      wb_rd_r;
   logic [XLEN-1:0] wb_data_r;
   logic            request, illegal, misaligned, accept, capture, stall;
   logic [3:0]      size;
   logic [XLEN-1:0] store_lanes, load_result;
   logic [NB-1:0]   lane_en;

   assign request    = ex_valid & (ex_load | ex_store);
   assign size       = size_of(ex_funct3);
   assign misaligned = |(ex_addr[2:0] & 3'(size - 4'd1));

   // Classify the incoming op: encodings this XLEN cannot execute are illegal.
   always_comb begin
      illegal = 1'b0;
      if (ex_load && ex_store) begin
         illegal = 1'b1;
      end else if (ex_load) begin
         case (ex_funct3)
            F3_D, F3_WU: illegal = (XLEN == 32);
            3'b111:      illegal = 1'b1;
            default:     illegal = 1'b0;
         endcase
      end else if (ex_store) begin
         illegal = (XLEN == 32) ? (ex_funct3 > F3_W) : (ex_funct3 > F3_D);
      end
   end

   // Next-state, wait counter and fault decision; mem_ready on the last wait cycle still completes.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      stall   = 1'b0;
      accept  = 1'b0;
      capture = 1'b0;
      fault_n = 1'b0;
      cause_n = FAULT_NONE;
      case (state)
         IDLE: begin
            if (request) begin
               if (illegal) begin
                  fault_n = 1'b1;
                  cause_n = FAULT_ILLEGAL;
               end else if (misaligned) begin
                  fault_n = 1'b1;
                  cause_n = FAULT_MISALIGN;
               end else begin
                  accept  = 1'b1;
                  stall   = 1'b1;
                  cnt_n   = '0;
                  state_n = REQ;
               end
            end
         end
         REQ: begin
            stall = 1'b1;
            if (mem_ready) begin
               capture = 1'b1;
               cnt_n   = '0;
               state_n = RESP;
            end else if (cnt == CW'(MAX_WAIT - 1)) begin
               fault_n = 1'b1;
               cause_n = FAULT_TIMEOUT;
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, counter, op capture at accept and load-result capture on the ready cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         op_addr   <= '0;
         op_data   <= '0;
         op_funct3 <= '0;
         op_rd     <= '0;
         op_store  <= 1'b0;
         fault_r   <= 1'b0;
         cause_r   <= FAULT_NONE;
         wb_rd_r   <= '0;
         wb_data_r <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         fault_r <= fault_n;
         cause_r <= cause_n;
         if (accept) begin
            op_addr   <= ex_addr;
            op_data   <= ex_store_data;
            op_funct3 <= ex_funct3;
            op_rd     <= ex_rd;
            op_store  <= ex_store;
         end
         if (capture && !op_store && (op_rd != 5'd0)) begin
            wb_rd_r   <= op_rd;
            wb_data_r <= load_result;
         end
      end
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3      (op_funct3),
      .lane        (op_addr[LW-1:0]),
      .store_data  (op_data),
      .load_raw    (mem_output),
      .store_lanes (store_lanes),
      .byte_en     (lane_en),
      .load_result (load_result)
   );

   assign mem_enable  = (state == REQ);
   assign mem_r_w     = mem_enable & op_store;
   assign mem_address = mem_enable ? {op_addr[XLEN-1:LW], {LW{1'b0}}} : '0;
   assign mem_input   = mem_r_w ? store_lanes : '0;
   assign mem_byte_en = mem_r_w ? lane_en : '0;
   assign lsu_stall   = stall;
   assign wb_valid    = (state == RESP) && !op_store && (op_rd != 5'd0);
   assign wb_rd       = wb_rd_r;
   assign wb_data     = wb_data_r;
   assign fault       = fault_r;
   assign fault_cause = cause_r;

endmodule
